// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, frame sync byte
// and the mod-256 checksum helper.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs accepted payload bytes MSB-first into 32-bit words and pulses word_ready
// for one cycle after the fourth byte of each word.
module loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready,
    output logic        word_last
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        word_ready_q, word_ready_d;

    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        word_ready_d = 1'b0;
        if (clear) begin
            byte_cnt_d = 2'd0;
            shift_d    = 32'd0;
        end else if (byte_valid) begin
            shift_d      = {shift_q[23:0], byte_in};
            byte_cnt_d   = byte_cnt_q + 2'd1;
            word_ready_d = (byte_cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q   <= 2'd0;
            shift_q      <= 32'd0;
            word_ready_q <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            word_ready_q <= word_ready_d;
        end
    end

    // The shift register holds the finished word during the strobe cycle; it only
    // moves again on the next accepted byte.
    assign word       = shift_q;
    assign word_ready = word_ready_q;
    assign word_last  = (byte_cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader into instruction memory; holds the CPU in reset until a
// frame with a good checksum has loaded. Define LOADER_TIMEOUT_EN for inter-byte timeout.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int MEM_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset_out,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic                accept;
    logic                asm_clear;
    logic                asm_valid;
    logic                asm_last;
    logic                asm_ready;
    logic [31:0]         asm_word;
    logic [15:0]         full_len;
    logic                active;

    assign in_ready = (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign accept   = in_valid && in_ready;
    assign full_len = {in_data, len_q[7:0]};
    assign active   = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign asm_valid = accept && (state_q == ST_DATA);

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    // Idle cycles are counted only mid-frame; any accepted byte restarts the count.
    always_comb begin
        tmo_d = tmo_q;
        if (accept || !active) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign tmo_hit = active && !accept && (tmo_q == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sum_d     = sum_q;
        words_d   = words_q;
        addr_d    = addr_q;
        asm_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d   = ST_LEN_LO;
                    sum_d     = 8'd0;
                    asm_clear = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = full_len;
                    if (full_len > 16'(MEM_WORDS)) begin
                        state_d = ST_ERROR;
                    end else if (full_len == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    sum_d = csum_add(sum_q, in_data);
                    // Count and address are committed on the completing byte so they
                    // line up with the strobe in the following cycle.
                    if (asm_last) begin
                        words_d = words_q + 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        if ((16'(words_q) + 16'd1) == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (csum_add(sum_q, in_data) == 8'd0) ? ST_DONE : ST_ERROR;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (tmo_hit) begin
            state_d = ST_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= 16'd0;
            sum_q   <= 8'd0;
            words_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            words_q <= words_d;
            addr_q  <= addr_d;
        end
    end

    loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (in_data),
        .word       (asm_word),
        .word_ready (asm_ready),
        .word_last  (asm_last)
    );

    assign mem_we        = asm_ready;
    assign mem_addr      = addr_q;
    assign mem_wdata     = asm_word;
    assign cpu_reset_out = (state_q != ST_DONE);
    assign load_done     = (state_q == ST_DONE);
    assign load_error    = (state_q == ST_ERROR);
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames plus randomized frames checked against a
// frame-parsing reference model.
module tb_program_loader;

    localparam int ADDR_W    = 8;
    localparam int MEM_WORDS = 256;
    localparam int TMO       = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset_out;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset_out(cpu_reset_out), .load_done(load_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    int          passes = 0;
    int          total  = 0;
    int          we_count = 0;
    logic [31:0] shadow  [0:MEM_WORDS-1];
    logic [31:0] exp_mem [0:MEM_WORDS-1];
    logic        exp_done, exp_err;
    int          exp_words;
    logic [7:0]  fr[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            shadow[mem_addr] = mem_wdata;
            we_count++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        reset = 1'b0;
        we_count = 0;
        for (int i = 0; i < MEM_WORDS; i++) shadow[i] = 32'h0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        if (in_ready !== 1'b1) return;
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    // mode 0: back-to-back, 1: one idle cycle before every byte, 2: random gaps
    task automatic send_stream(input logic [7:0] q[$], input int mode);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i], (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3)));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reference: parse the byte list as a frame and derive the final outcome.
    task automatic model(input logic [7:0] q[$]);
        int         i;
        int         len;
        logic [7:0] sum;
        i = 0;
        sum = 8'd0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_words = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        if (i + 3 > q.size()) return;
        len = int'(q[i+1]) + 256 * int'(q[i+2]);
        i += 3;
        if (len > MEM_WORDS) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < len; w++) begin
            if (i + 4 > q.size()) return;
            exp_mem[w] = {q[i], q[i+1], q[i+2], q[i+3]};
            for (int k = 0; k < 4; k++) sum = 8'((int'(sum) + int'(q[i+k])) % 256);
            exp_words++;
            i += 4;
        end
        if (i >= q.size()) return;
        if (((int'(sum) + int'(q[i])) % 256) == 0) exp_done = 1'b1;
        else exp_err = 1'b1;
    endtask

    task automatic check_outcome(input string tag);
        chk({tag, ".done"},  32'(load_done),     32'(exp_done));
        chk({tag, ".err"},   32'(load_error),    32'(exp_err));
        chk({tag, ".cpurst"}, 32'(cpu_reset_out), 32'(!exp_done));
        chk({tag, ".ready"}, 32'(in_ready),      32'(!(exp_done || exp_err)));
        chk({tag, ".words"}, 32'(words_loaded),  32'(exp_words));
        chk({tag, ".wecnt"}, 32'(we_count),      32'(exp_words));
        for (int w = 0; w < exp_words; w++)
            chk($sformatf("%s.mem%0d", tag, w), shadow[w], exp_mem[w]);
    endtask

    task automatic build_random(output logic [7:0] q[$]);
        int         len;
        int         noise;
        logic [7:0] sum;
        logic [7:0] b;
        q = {};
        sum = 8'd0;
        noise = int'($urandom_range(0, 2));
        for (int i = 0; i < noise; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            q.push_back(b);
        end
        len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 300)) : int'($urandom_range(0, 6));
        q.push_back(8'hA5);
        q.push_back(8'(len));
        q.push_back(8'(len >> 8));
        if (len <= MEM_WORDS) begin
            for (int i = 0; i < 4 * len; i++) begin
                b = 8'($urandom);
                sum = sum + b;
                q.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) q.push_back(8'(0 - sum + int'($urandom_range(1, 255))));
            else q.push_back(8'(0 - sum));
        end
    endtask

    logic [7:0] frame1[$] = '{8'hA5, 8'h02, 8'h00, 8'hB8, 8'h01, 8'h00, 8'h00,
                              8'h00, 8'hC3, 8'h90, 8'h90, 8'h64};

    initial begin
        // Reset state
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        idle(2);
        do_reset();
        chk("rst.ready",  32'(in_ready), 32'd1);
        chk("rst.we",     32'(mem_we), 32'd0);
        chk("rst.addr",   32'(mem_addr), 32'd0);
        chk("rst.wdata",  mem_wdata, 32'd0);
        chk("rst.cpurst", 32'(cpu_reset_out), 32'd1);
        chk("rst.done",   32'(load_done), 32'd0);
        chk("rst.err",    32'(load_error), 32'd0);
        chk("rst.words",  32'(words_loaded), 32'd0);

        // Good two-word frame; done must appear the cycle after the CSUM byte
        send_stream(frame1, 0);
        chk("t1.done_timing", 32'(load_done), 32'd1);
        idle(3);
        model(frame1);
        chk("t1.mem0_const", shadow[0], 32'hB8010000);
        chk("t1.mem1_const", shadow[1], 32'h00C39090);
        check_outcome("t1");

        // Bad checksum
        do_reset();
        fr = frame1;
        fr[11] = 8'h65;
        send_stream(fr, 0);
        idle(3);
        model(fr);
        chk("t2.err_const", 32'(load_error), 32'd1);
        check_outcome("t2");

        // Oversize length: error the cycle after LEN_HI
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        chk("t3.err_before", 32'(load_error), 32'd0);
        send_byte(8'h01, 0);
        chk("t3.err_timing", 32'(load_error), 32'd1);
        idle(3);
        fr = '{8'hA5, 8'h01, 8'h01};
        model(fr);
        check_outcome("t3");

        // Noise then empty frame
        do_reset();
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_stream(fr, 2);
        idle(3);
        model(fr);
        chk("t4.done_const", 32'(load_done), 32'd1);
        check_outcome("t4");

        // Reset mid-frame, then resend with in_valid toggling
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(frame1[i], 0);
        do_reset();
        chk("t5.rst_words", 32'(words_loaded), 32'd0);
        chk("t5.rst_ready", 32'(in_ready), 32'd1);
        send_stream(frame1, 1);
        idle(3);
        model(frame1);
        check_outcome("t5");

        // Long stall after the length low byte
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
`ifdef LOADER_TIMEOUT_EN
        idle(TMO + 6);
        chk("t6.tmo_err",    32'(load_error), 32'd1);
        chk("t6.tmo_cpurst", 32'(cpu_reset_out), 32'd1);
        chk("t6.tmo_ready",  32'(in_ready), 32'd0);
`else
        idle(2000);
        chk("t6.stall_err",   32'(load_error), 32'd0);
        chk("t6.stall_ready", 32'(in_ready), 32'd1);
        for (int i = 2; i < frame1.size(); i++) send_byte(frame1[i], 0);
        idle(3);
        model(frame1);
        check_outcome("t6");
`endif

        // Randomized frames
        for (int n = 0; n < 25; n++) begin
            do_reset();
            build_random(fr);
            send_stream(fr, 2);
            idle(4);
            model(fr);
            check_outcome($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
